pm_controller: RTL
==================

// Module: pm_controller
// PURPOSE
// Peripheral side of the powerManagement interface for the or1200 wrapper; this block consumes the
// CPU's PM outputs and drives pm cpustall. It sequences doze/sleep entry and exit: debounced gate entry,
// stall while sleeping, wake on interrupt/wakeup, timed stall release. It also generates a clock-enable
// for slowed peripherals from the clksd code. Sits beside the or1200 instance, sharing its clock and the
// same 20-bit interrupt vector.
// PARAMETERS
// GATE_DELAY  4   cycles cpu_gate must stay high in GATE_WAIT before SLEEP (>=1)
// WAKE_DELAY  8   cycles stall is held in WAKE_WAIT after a wake event (>=1)
// NUM_IRQ     20  width of the interrupt vector monitored for wake
// PORTS
// clock          in   1        system clock, single domain
// reset          in   1        synchronous, active-high reset
// cpu_gate_i     in   1        or1200 pm_cpu_gate_o (CPU requests clock gate)
// wakeup_i       in   1        or1200 pm_wakeup_o
// lvolt_i        in   1        or1200 pm_lvolt_o (low-voltage request)
// clksd_i        in   4        or1200 pm_clksd_o (slowdown code 0..15)
// irq_i          in   NUM_IRQ  interrupt lines (same vector as or1200 interrupts)
// force_stall_i  in   1        external/debug stall request
// cpustall_o     out  1        to or1200 pm_cpustall_i
// periph_ce_o    out  1        peripheral clock enable, 1 pulse per clksd_i+1 cycles
// lvolt_req_o    out  1        low-voltage request to regulator, valid only in SLEEP
// state_o        out  2        FSM state: 0 RUN, 1 GATE_WAIT, 2 SLEEP, 3 WAKE_WAIT
// BEHAVIOUR
// - All outputs registered. Reset: state RUN, cpustall_o=0, periph_ce_o=0, lvolt_req_o=0, cnt=0,
//   div_cnt=0, armed=1. A mid-sequence reset aborts immediately; cpustall_o is 0 after that edge.
// - wake = wakeup_i | (|irq_i), sampled at each edge.
// - RUN: on an edge with cpu_gate_i=1 & armed & !wake -> GATE_WAIT, cnt=0. An edge with cpu_gate_i=0
//   sets armed=1.
// - GATE_WAIT: wake or cpu_gate_i=0 -> RUN (wake wins over completion). Else if cnt==GATE_DELAY-1
//   -> SLEEP, latch lvolt_req_o<=lvolt_i; else cnt++.
// - SLEEP: on wake -> WAKE_WAIT, cnt=0, lvolt_req_o<=0, armed=0. Otherwise hold.
// - WAKE_WAIT: ignores further wakes and cpu_gate_i. cnt==WAKE_DELAY-1 -> RUN; else cnt++.
// - armed=0 after a wake, so a still-high cpu_gate_i cannot re-enter sleep until it has been seen low.
// - cpustall_o <= (next_state in {SLEEP, WAKE_WAIT}) | force_stall_i.
//   force_stall_i has 1-cycle latency and does not alter the FSM.
// - Divider: if div_cnt==0 then div_cnt<=clksd_i and periph_ce_o<=1; else div_cnt-- and periph_ce_o<=0.
//   A clksd_i change takes effect at the next reload. clksd_i=0 gives periph_ce_o constantly 1.
// - While next_state==SLEEP: periph_ce_o<=0 and div_cnt<=0, so the first WAKE_WAIT cycle has ce=1.
// - Entry latency: cpu_gate_i sampled high at edge k -> SLEEP and cpustall_o=1 after edge
//   k+GATE_DELAY. Exit: wake at edge m -> RUN and cpustall_o=0 after edge m+WAKE_DELAY
//   (given force_stall_i=0).
// - cnt width: $clog2(max(GATE_DELAY,WAKE_DELAY))+1; no wrap is reachable.
// TESTING
// - Reset with clksd_i=0, then cpu_gate_i=1 from edge 1 -> state_o=1 after edge 1, state_o=2 and
//   cpustall_o=1 after edge 5, periph_ce_o=0 from edge 5.
// - In SLEEP pulse irq_i[7] for 1 cycle at edge m -> state_o=3 after edge m; state_o=0 and
//   cpustall_o=0 after edge m+8. With cpu_gate_i still 1 the block stays in RUN; drop cpu_gate_i for
//   1 cycle then raise it -> GATE_WAIT again.
// - In GATE_WAIT drop cpu_gate_i at cnt=2 -> RUN, cpustall_o never asserts. Assert wakeup_i on the
//   completion edge -> RUN, not SLEEP.
// - clksd_i=3 in RUN -> periph_ce_o pattern 1,0,0,0 repeating. Change to 1 mid-count -> new period 2
//   starting after the next pulse. clksd_i=0 -> constant 1.
// - lvolt_i=1 at SLEEP entry -> lvolt_req_o=1 during SLEEP; cleared on the WAKE_WAIT entry edge.
// - force_stall_i=1 in RUN -> cpustall_o=1 one edge later with the FSM unaffected. Assert reset in
//   WAKE_WAIT -> state_o=0 and all outputs 0 after that edge.

Source files
------------

// File: rtl/pm_controller.sv
// rtl/pm_controller.sv - power-management sequencer: gate debounce, sleep stall, timed wake, peripheral clock enable
module pm_controller #(
    parameter int GATE_DELAY = 4,
    parameter int WAKE_DELAY = 8,
    parameter int NUM_IRQ    = 20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_gate_i,
    input  logic               wakeup_i,
    input  logic               lvolt_i,
    input  logic [3:0]         clksd_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               force_stall_i,
    output logic               cpustall_o,
    output logic               periph_ce_o,
    output logic               lvolt_req_o,
    output logic [1:0]         state_o
);

    localparam int MAX_DELAY = (GATE_DELAY > WAKE_DELAY) ? GATE_DELAY : WAKE_DELAY;
    localparam int CW = $clog2(MAX_DELAY) + 1;
    localparam logic [CW-1:0] GATE_LAST = CW'(GATE_DELAY - 1);
    localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_DELAY - 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        GATE_WAIT = 2'd1,
        SLEEP     = 2'd2,
        WAKE_WAIT = 2'd3
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_next;
    logic          armed, armed_next;
    logic          lvolt_next;
    logic          wake;
    logic [3:0]    div_cnt;

    assign wake    = wakeup_i | (|irq_i);
    assign state_o = state;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        armed_next = armed;
        lvolt_next = lvolt_req_o;
        case (state)
            RUN: begin
                // armed blocks re-entry until the gate request has been seen low after a wake
                if (!cpu_gate_i) begin
                    armed_next = 1'b1;
                end else if (armed && !wake) begin
                    next_state = GATE_WAIT;
                    cnt_next   = '0;
                end
            end
            GATE_WAIT: begin
                if (wake || !cpu_gate_i) begin
                    next_state = RUN;
                end else if (cnt == GATE_LAST) begin
                    next_state = SLEEP;
                    lvolt_next = lvolt_i;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            SLEEP: begin
                if (wake) begin
                    next_state = WAKE_WAIT;
                    cnt_next   = '0;
                    lvolt_next = 1'b0;
                    armed_next = 1'b0;
                end
            end
            WAKE_WAIT: begin
                if (cnt == WAKE_LAST) begin
                    next_state = RUN;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            armed       <= 1'b1;
            lvolt_req_o <= 1'b0;
            cpustall_o  <= 1'b0;
            periph_ce_o <= 1'b0;
            div_cnt     <= 4'd0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            armed       <= armed_next;
            lvolt_req_o <= lvolt_next;
            cpustall_o  <= (next_state == SLEEP) || (next_state == WAKE_WAIT) || force_stall_i;
            // parking the divider at zero makes the first wake cycle produce an enable pulse
            if (next_state == SLEEP) begin
                periph_ce_o <= 1'b0;
                div_cnt     <= 4'd0;
            end else if (div_cnt == 4'd0) begin
                periph_ce_o <= 1'b1;
                div_cnt     <= clksd_i;
            end else begin
                periph_ce_o <= 1'b0;
                div_cnt     <= div_cnt - 4'd1;
            end
        end
    end

endmodule
